// File: rtl/gcl_step_engine.sv
// Small-step executor for the guarded command language over a ROM program and variable file.
// Optional trace outputs are enabled by defining GCL_TRACE_EN.
module gcl_step_engine #(
  parameter int DW = 16,
  parameter int NV = 8,
  parameter int AW = 8,
  parameter int HD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic          ch_req,
  input  logic          ch_ack,
  input  logic          ch_bit,
  input  logic          var_we,
  input  logic [2:0]    var_waddr,
  input  logic [DW-1:0] var_wdata,
  input  logic [2:0]    var_raddr,
  output logic [DW-1:0] var_rdata,
  output logic [15:0]   steps
`ifdef GCL_TRACE_EN
  ,
  output logic          tr_valid,
  output logic [AW-1:0] tr_pc,
  output logic [3:0]    tr_op
`endif
);

  localparam int SPW = $clog2(HD + 1);
  localparam int SIW = (HD > 1) ? $clog2(HD) : 1;

  localparam logic [1:0] ST_NORMAL  = 2'b00;
  localparam logic [1:0] ST_EXCEPT  = 2'b01;
  localparam logic [1:0] ST_WRONG   = 2'b10;
  localparam logic [1:0] ST_BLOCKED = 2'b11;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, CHWAIT, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   choice_off;
  logic [SPW-1:0]  sp;
  logic [AW-1:0]   stack [HD];
  logic [DW-1:0]   vars [NV];

  logic [3:0]      op;
  logic [2:0]      x;
  logic [2:0]      y;
  logic [DW-1:0]   imm_ext;
  logic [AW-1:0]   off_aw;
  logic [SIW-1:0]  top_idx;
  logic [SIW-1:0]  push_idx;

  logic [AW-1:0]   nxt_pc;
  logic            do_halt;
  logic [1:0]      halt_code;
  logic            do_push;
  logic            do_pop;
  logic            do_choice;
  logic            do_write;

  assign op        = prog_data[15:12];
  assign x         = prog_data[11:9];
  assign y         = prog_data[8:6];
  assign imm_ext   = {{(DW-6){prog_data[5]}}, prog_data[5:0]};
  // Truncating the 12-bit offset to AW bits gives the modulo-2^AW pc arithmetic directly.
  assign off_aw    = prog_data[AW-1:0];
  assign top_idx   = SIW'(sp - 1'b1);
  assign push_idx  = SIW'(sp);
  assign prog_addr = pc;
  assign var_rdata = vars[var_raddr];

  always_comb begin
    nxt_pc    = pc + 1'b1;
    do_halt   = 1'b0;
    halt_code = ST_NORMAL;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_choice = 1'b0;
    do_write  = 1'b0;
    case (op)
      4'h0: ;
      4'h1: if (vars[x] == '0) begin do_halt = 1'b1; halt_code = ST_WRONG; end
      4'h2: if (vars[x] == '0) begin do_halt = 1'b1; halt_code = ST_BLOCKED; end
      4'h3: do_write = 1'b1;
      4'h4, 4'h5: do_choice = 1'b1;
      4'h6: nxt_pc = pc + off_aw;
      4'h7: if (sp == SPW'(HD)) begin do_halt = 1'b1; halt_code = ST_WRONG; end
            else do_push = 1'b1;
      4'h8: if (sp == '0) begin do_halt = 1'b1; halt_code = ST_WRONG; end
            else do_pop = 1'b1;
      4'h9: if (sp == '0) begin do_halt = 1'b1; halt_code = ST_EXCEPT; end
            else begin do_pop = 1'b1; nxt_pc = stack[top_idx]; end
      4'hA: do_halt = 1'b1;
      default: begin do_halt = 1'b1; halt_code = ST_WRONG; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      choice_off <= '0;
      sp         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= ST_NORMAL;
      ch_req     <= 1'b0;
      steps      <= '0;
      for (int i = 0; i < NV; i++) vars[i] <= '0;
      for (int i = 0; i < HD; i++) stack[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (var_we) vars[var_waddr] <= var_wdata;
          if (start) begin
            state  <= FETCH;
            pc     <= '0;
            sp     <= '0;
            steps  <= '0;
            done   <= 1'b0;
            busy   <= 1'b1;
            status <= ST_NORMAL;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: state <= EXEC;
        EXEC: begin
          if (steps != 16'hFFFF) steps <= steps + 16'd1;
          if (do_write) vars[x] <= vars[y] + imm_ext;
          if (do_push) begin
            stack[push_idx] <= pc + off_aw;
            sp              <= sp + 1'b1;
          end
          if (do_pop) sp <= sp - 1'b1;
          if (do_halt) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            status <= halt_code;
          end else if (do_choice) begin
            state      <= CHWAIT;
            ch_req     <= 1'b1;
            choice_off <= off_aw;
          end else begin
            state <= FETCH;
            pc    <= nxt_pc;
          end
        end
        CHWAIT: begin
          if (ch_ack) begin
            ch_req <= 1'b0;
            pc     <= ch_bit ? (pc + choice_off) : (pc + 1'b1);
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCL_TRACE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_valid <= 1'b0;
      tr_pc    <= '0;
      tr_op    <= '0;
    end else begin
      tr_valid <= (state == EXEC);
      tr_pc    <= pc;
      tr_op    <= op;
    end
  end
`endif

endmodule

// File: tb/tb_gcl_step_engine.sv
// Self-checking bench for gcl_step_engine: directed test-plan programs plus random forward-only
// programs, each compared against an instruction-level interpreter of the language.
module tb_gcl_step_engine;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int HD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, ch_req;
  logic [1:0]    status;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data = '0;
  logic          ch_ack, ch_bit;
  logic          var_we = 1'b0;
  logic [2:0]    var_waddr = '0;
  logic [DW-1:0] var_wdata = '0;
  logic [2:0]    var_raddr = '0;
  logic [DW-1:0] var_rdata;
  logic [15:0]   steps;
`ifdef GCL_TRACE_EN
  logic          tr_valid;
  logic [AW-1:0] tr_pc;
  logic [3:0]    tr_op;
`endif

  gcl_step_engine #(.DW(DW), .NV(8), .AW(AW), .HD(HD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .status(status),
    .prog_addr(prog_addr), .prog_data(prog_data), .ch_req(ch_req), .ch_ack(ch_ack),
    .ch_bit(ch_bit), .var_we(var_we), .var_waddr(var_waddr), .var_wdata(var_wdata),
    .var_raddr(var_raddr), .var_rdata(var_rdata), .steps(steps)
`ifdef GCL_TRACE_EN
    , .tr_valid(tr_valid), .tr_pc(tr_pc), .tr_op(tr_op)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) prog_data <= rom[prog_addr];

  logic [DW-1:0] mv [8];
  bit            ch_bits [256];
  int            ch_delay [256];
  int            ch_idx;
  int            wait_cnt;
  int            req_cnt;
  int            checks = 0;
  int            errors = 0;

  // Choice responder: acks after ch_delay[] cycles of ch_req, consuming ch_bits[] in order.
  initial begin
    ch_ack = 1'b0; ch_bit = 1'b0; wait_cnt = 0; ch_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ch_ack = 1'b0; wait_cnt = 0;
      end else begin
        if (ch_ack) begin ch_idx++; ch_ack = 1'b0; wait_cnt = 0; end
        else if (ch_req) begin
          if (wait_cnt >= ch_delay[ch_idx & 255]) begin
            ch_ack = 1'b1; ch_bit = ch_bits[ch_idx & 255];
          end else wait_cnt++;
        end
      end
    end
  end

  initial begin
    req_cnt = 0;
    forever begin
      @(negedge clk);
      if (ch_req) req_cnt++;
    end
  end

  function automatic logic [15:0] ei(int op, int x, int y, int imm);
    return {4'(op), 3'(x), 3'(y), 6'(imm)};
  endfunction

  function automatic logic [15:0] eo(int op, int off);
    return {4'(op), 12'(off)};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000;
  endtask

  task automatic write_var(input int idx, input logic [DW-1:0] val);
    @(negedge clk);
    var_we = 1'b1; var_waddr = 3'(idx); var_wdata = val;
    @(negedge clk);
    var_we = 1'b0;
    mv[idx] = val;
  endtask

  task automatic set_choice(input int k, input bit b, input int d);
    ch_bits[(ch_idx + k) & 255] = b;
    ch_delay[(ch_idx + k) & 255] = d;
  endtask

  // Interpreter of the language: runs the ROM program on mv using the queued choices.
  task automatic model_run(input int base, output logic [1:0] st, output int nsteps,
                           output int ncyc, output int nreq);
    int pc, nxt, op, x, y, imm, off, ci, d;
    int stk[$];
    bit halted;
    logic [15:0] w;
    logic signed [5:0] s6;
    logic signed [11:0] s12;
    pc = 0; ci = base; halted = 0; st = 2'b00; nsteps = 0; ncyc = 0; nreq = 0;
    for (int guard = 0; guard < 20000 && !halted; guard++) begin
      w = rom[pc];
      op = int'(w[15:12]); x = int'(w[11:9]); y = int'(w[8:6]);
      s6 = w[5:0]; imm = s6;
      s12 = w[11:0]; off = s12;
      if (nsteps < 65535) nsteps++;
      ncyc += 2;
      nxt = pc + 1;
      case (op)
        0: ;
        1: if (mv[x] == 0) begin halted = 1; st = 2'b10; end
        2: if (mv[x] == 0) begin halted = 1; st = 2'b11; end
        3: mv[x] = mv[y] + DW'(imm);
        4, 5: begin
          d = ch_delay[ci & 255];
          ncyc += 1 + d; nreq += 1 + d;
          if (ch_bits[ci & 255]) nxt = pc + off;
          ci++;
        end
        6: nxt = pc + off;
        7: if (stk.size() == HD) begin halted = 1; st = 2'b10; end
           else stk.push_back((pc + off) & ((2**AW) - 1));
        8: if (stk.size() == 0) begin halted = 1; st = 2'b10; end
           else void'(stk.pop_back());
        9: if (stk.size() == 0) begin halted = 1; st = 2'b01; end
           else nxt = stk.pop_back();
        10: halted = 1;
        default: begin halted = 1; st = 2'b10; end
      endcase
      pc = nxt & ((2**AW) - 1);
    end
  endtask

  // Start a run, wait for done, then compare outcome, counts, timing and every variable.
  task automatic apply_stimulus(input string tag, input int pulse_at);
    logic [1:0] est;
    int esteps, ecyc, ereq, cyc;
    model_run(ch_idx, est, esteps, ecyc, ereq);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; req_cnt = 0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_status"}, 32'(status), 32'(est));
    check_output({tag, "_steps"}, 32'(steps), 32'(esteps));
    check_output({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    check_output({tag, "_reqcyc"}, 32'(req_cnt), 32'(ereq));
    for (int i = 0; i < 8; i++) begin
      var_raddr = 3'(i); #1;
      check_output($sformatf("%s_v%0d", tag, i), 32'(var_rdata), 32'(mv[i]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_status"}, 32'(status), 32'd0);
    check_output({tag, "_chreq"}, 32'(ch_req), 32'd0);
    check_output({tag, "_addr"}, 32'(prog_addr), 32'd0);
    check_output({tag, "_steps"}, 32'(steps), 32'd0);
    for (int i = 0; i < 8; i++) begin
      var_raddr = 3'(i); #1;
      check_output($sformatf("%s_v%0d", tag, i), 32'(var_rdata), 32'd0);
    end
  endtask

  task automatic load_assign_prog();
    clear_rom();
    rom[0] = ei(3, 1, 0, 3);
    rom[1] = ei(1, 1, 0, 0);
    rom[2] = ei(10, 0, 0, 0);
  endtask

  initial begin
    int r, cyc, len;
    for (int i = 0; i < 8; i++) mv[i] = '0;
    for (int i = 0; i < 256; i++) begin ch_bits[i] = 0; ch_delay[i] = 0; end
    clear_rom();

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    write_var(0, 16'd5);
    load_assign_prog();
    apply_stimulus("assign", -1);
    check_output("assign_v1_const", 32'(mv[1]), 32'd8);

    write_var(2, 16'd0);
    clear_rom(); rom[0] = ei(1, 2, 0, 0);
    apply_stimulus("assert", -1);
    clear_rom(); rom[0] = ei(2, 2, 0, 0);
    apply_stimulus("assume", -1);

    clear_rom();
    rom[0] = eo(4, 3); rom[1] = ei(3, 0, 0, 1); rom[2] = eo(6, 2); rom[3] = ei(3, 0, 0, -1);
    write_var(0, 16'd0); set_choice(0, 0, 0);
    apply_stimulus("choice0", -1);
    write_var(0, 16'd0); set_choice(0, 1, 0);
    apply_stimulus("choice1", -1);
    check_output("choice1_v0_const", 32'(mv[0]), 32'h0000FFFF);
    write_var(0, 16'd0); set_choice(0, 0, 4);
    apply_stimulus("choice_slow", -1);

    clear_rom();
    rom[0] = eo(7, 3); rom[1] = ei(9, 0, 0, 0); rom[2] = eo(6, 2); rom[3] = ei(3, 3, 3, 7);
    write_var(3, 16'd0);
    apply_stimulus("catch", -1);
    clear_rom(); rom[0] = ei(9, 0, 0, 0);
    apply_stimulus("raise_top", -1);
    clear_rom(); rom[0] = ei(8, 0, 0, 0);
    apply_stimulus("endtry_empty", -1);

    clear_rom();
    rom[0] = eo(5, 3); rom[1] = ei(3, 0, 0, 1); rom[2] = eo(6, -2);
    write_var(0, 16'd0);
    set_choice(0, 0, 1); set_choice(1, 0, 0); set_choice(2, 0, 2); set_choice(3, 1, 0);
    apply_stimulus("loop", -1);
    check_output("loop_steps_const", 32'(steps), 32'd11);

    clear_rom();
    for (int i = 0; i <= HD; i++) rom[i] = eo(7, 1);
    apply_stimulus("try_overflow", -1);
    clear_rom();
    for (int i = 0; i < HD; i++) rom[i] = eo(7, HD + 2 - i);
    rom[HD] = ei(9, 0, 0, 0); rom[HD + 1] = 16'hF000;
    apply_stimulus("raise_full", -1);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 3));
        write_var(i, (r == 0) ? 16'd0 : 16'($urandom));
      end
      for (int k = 0; k < 64; k++) set_choice(k, 1'($urandom), int'($urandom_range(0, 3)));
      clear_rom();
      len = 16;
      for (int i = 0; i < len; i++) begin
        r = int'($urandom_range(0, 19));
        case (r)
          0, 1:        rom[i] = 16'h0000;
          2, 3:        rom[i] = ei(1, $urandom_range(0, 7), 0, 0);
          4:           rom[i] = ei(2, $urandom_range(0, 7), 0, 0);
          9, 10:       rom[i] = eo(4, $urandom_range(1, 4));
          11:          rom[i] = eo(5, $urandom_range(1, 4));
          12:          rom[i] = eo(6, $urandom_range(1, 4));
          13, 14:      rom[i] = eo(7, $urandom_range(1, 4));
          15:          rom[i] = ei(8, 0, 0, 0);
          16:          rom[i] = ei(9, 0, 0, 0);
          17:          rom[i] = ei(10, 0, 0, 0);
          18:          rom[i] = {4'($urandom_range(11, 15)), 12'($urandom)};
          default:     rom[i] = ei(3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
        endcase
      end
      apply_stimulus($sformatf("rand%0d", t), (t % 2 == 0) ? 3 : -1);
    end

    clear_rom(); rom[0] = eo(4, 2);
    set_choice(0, 0, 20);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!ch_req && cyc < 50) begin @(negedge clk); cyc++; end
    check_output("abort_req_seen", 32'(ch_req), 32'd1);
    rst_n = 1'b0; #1;
    for (int i = 0; i < 8; i++) mv[i] = '0;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    write_var(0, 16'd5);
    load_assign_prog();
    apply_stimulus("after_abort", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcl_step_engine.md
# gcl_step_engine

Forward small-step executor for the team's guarded command language (assert, assume, assign, choice, seq, skip, raise, catch, loop). It runs a flattened program from an external ROM over a variable file and resolves nondeterminism through a choice handshake. It ends in one of four outcomes: normal, exceptional, wrong, blocked. These match the N / X / W postconditions and the blocked case of the weakest-precondition rules, so the block serves as the operational counterpart used to cross-check proved triples on concrete states.

## Interface
- `DW`, 16: variable width.
- `NV`, 8: number of variables; indices are 3 bits, and `NV` ≤ 8.
- `AW`, 8: program address width; `AW` ≤ 12.
- `HD`, 4: handler (try) stack depth.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin execution at pc 0; accepted only while `busy`=0.
- `busy` out 1: program running.
- `done` out 1: high from completion until the next accepted `start`.
- `status` out 2: outcome. 00 normal, 01 exception, 10 wrong, 11 blocked.
- `prog_addr` out AW: ROM address.
- `prog_data` in 16: ROM word, valid one cycle after `prog_addr`.
- `ch_req` out 1: choice requested.
- `ch_ack` in 1: choice supplied.
- `ch_bit` in 1: choice value, sampled when `ch_req` and `ch_ack` are both high.
- `var_we` in 1, `var_waddr` in 3, `var_wdata` in DW: variable write port; ignored while `busy`.
- `var_raddr` in 3, `var_rdata` out DW: combinational variable read.
- `steps` out 16: instructions retired, saturating at 0xFFFF.

## Operation
- Encoding: `op`=[15:12]; `x`=[11:9]; `y`=[8:6]; `imm`=[5:0], signed; `off`=[11:0], signed, relative to the current pc.
- Opcodes:
  - 0 SKIP: no effect.
  - 1 ASSERT x: `var[x]`=0 → halt wrong.
  - 2 ASSUME x: `var[x]`=0 → halt blocked.
  - 3 ASSIGN: `var[x]` ← `var[y]` + sext(`imm`), truncated to DW (wraps).
  - 4 CHOICE off: request a choice. `ch_bit`=0 → pc+1 (s1); 1 → pc+off (s2).
  - 5 LOOP off: request a choice. `ch_bit`=0 → pc+1 (body, which ends in a JMP back to the LOOP); 1 → pc+off (exit).
  - 6 JMP off: pc ← pc+off.
  - 7 TRY off: push pc+off as the handler; stack full → halt wrong.
  - 8 ENDTRY: pop; stack empty → halt wrong.
  - 9 RAISE: stack non-empty → pop into pc; empty → halt exception.
  - A HALT: halt normal.
  - B–F: halt wrong.
- pc arithmetic is modulo 2^AW and wraps silently.
- Every instruction that reaches its execute state increments `steps`, including the one that halts.
- FSM states:
  - IDLE: `start` → FETCH, with pc=0, stack emptied, `steps`=0, `done`=0, `busy`=1.
  - FETCH: drive `prog_addr`=pc → EXEC.
  - EXEC: decode `prog_data`. CHOICE/LOOP → CHWAIT; halting cases → DONE; otherwise → FETCH.
  - CHWAIT: `ch_req`=1. On `ch_ack`, take the branch → FETCH.
  - DONE: `busy`=0, `done`=1, `status` held → IDLE.
- `start` in DONE is accepted as from IDLE.
- The variable file persists across runs; only `var_we` or the program modifies it.

## Timing
- Reset values: `busy`=0, `done`=0, `status`=00, `ch_req`=0, `prog_addr`=0, `steps`=0, all variables 0, pc 0, stack empty, FSM in IDLE.
- Non-choice instruction: 2 cycles (FETCH, EXEC).
- Choice instruction: 3 cycles plus ack latency. `ch_ack` in the first CHWAIT cycle gives 3 cycles.
- `ch_req` rises the cycle after EXEC and falls the cycle after the handshake.
- `ch_ack` without `ch_req` is ignored.
- ASSIGN result is visible on `var_rdata` the cycle after EXEC.
- `busy` falls and `done` rises together, on the cycle after the halting EXEC.
- `start` is ignored while `busy`=1.
- Reset mid-run: immediate abort to reset values; any ROM or choice handshake in flight is discarded.
- RAISE with the stack at depth HD and TRY at depth HD-1 are both legal; only a push at depth HD is wrong.

## Configuration
- `GCL_TRACE_EN` defined adds outputs `tr_valid` (1), `tr_pc` (AW) and `tr_op` (4). `tr_valid` pulses for one cycle on each EXEC, registered, so it appears the cycle after EXEC.
- `GCL_TRACE_EN` undefined: ports absent, no trace logic.
- Core behaviour and timing are identical either way.

## Test plan
- Assign/normal: v0=5; program ASSIGN v1,v0,+3; ASSERT v1; HALT → `status`=00, v1=8, `steps`=3, `done` 6 cycles after `start`.
- Assert vs assume: v2=0. ASSERT v2 → `status`=10. ASSUME v2 → `status`=11. Each gives `steps`=1.
- Choice: CHOICE +3; ASSIGN v0,v0,+1; JMP +2; ASSIGN v0,v0,-1; HALT with v0=0. `ch_bit`=0 → v0=1; `ch_bit`=1 → v0=0xFFFF. Ack delayed 4 cycles → `ch_req` held exactly until ack.
- Catch: TRY +3; RAISE; JMP +2; ASSIGN v3,v3,+7; HALT → v3=7, `status`=00. Top-level RAISE alone → `status`=01.
- Loop: LOOP +3; ASSIGN v0,v0,+1; JMP -2; HALT. Choice sequence 0,0,0,1 → v0=3, `steps`=11. Stack overflow: HD+1 nested TRY → `status`=10.
- Reset abort: assert `rst_n` low while in CHWAIT → all outputs at reset values next edge; a new `start` runs cleanly.
